pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/load_use_detect.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: hazard-controller FSM states, RV32I opcode constants and the NOP used for IF/ID flushes
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN       = 2'b00,
        LU_STALL  = 2'b01,
        IMEM_WAIT = 2'b10,
        REDIRECT  = 2'b11
    } hz_state_e;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP      = 32'h0000_0013;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID-stage source register that depends on the load currently in EX
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] id_instruction,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic        load_use
);
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       unused_bits;
    assign opcode      = id_instruction[6:0];
    assign rs1         = id_instruction[19:15];
    assign rs2         = id_instruction[24:20];
    assign unused_bits = ^{id_instruction[31:25], id_instruction[14:7]};
    assign rs1_used    = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign rs2_used    = opcode inside {OP_OP, OP_STORE, OP_BRANCH};
    assign load_use    = ex_mem_read && (ex_rd != 5'd0) &&
                         ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: Mealy stall/flush controller for a 5-stage pipeline; define PIPE_PERF_CNT_EN to enable the perf counters
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instruction,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  state_dbg,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);
    hz_state_e state;
    hz_state_e next_state;
    logic      load_use;
    load_use_detect u_lud (
        .id_instruction (id_instruction),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .load_use       (load_use)
    );
    always_ff @(posedge clk)
        state <= reset ? RUN : next_state;
    always_comb begin
        next_state  = RUN;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (branch_taken) begin
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            next_state  = REDIRECT;
        end else if (load_use && state == RUN) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            next_state  = LU_STALL;
        end else if (!imem_ready) begin
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
            next_state  = IMEM_WAIT;
        end else begin
            ifid_flush  = (state == REDIRECT);
        end
    end
    assign state_dbg = state;
`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (!pc_write && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_taken && flush_events != 32'hFFFF_FFFF)
                flush_events <= flush_events + 32'd1;
        end
    end
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif
endmodule
